// File: rtl/ir_loader.sv
// ir_loader: streams instruction words from an upstream valid/ready source
// into the IR register file. Each accepted word is registered and written
// in the following cycle, so throughput is at most one word every two cycles.
//
// Optional build macro IR_LOADER_CHECKSUM_EN: accumulates a running sum of
// the accepted words, compares it against an expected sum sampled with the
// start request, and flags a mismatch on o_error together with o_done.
module ir_loader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH-1:0] i_load_base,
  input  logic [ADDR_WIDTH-1:0] i_load_len,
  input  logic                  i_bank,
  input  logic                  i_load_abort,
  input  logic                  i_data_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
`ifdef IR_LOADER_CHECKSUM_EN
  input  logic [DATA_WIDTH-1:0] i_expected_sum,
  output logic [DATA_WIDTH-1:0] o_checksum,
`endif
  output logic                  o_data_ready,
  output logic                  o_ir_regfile_en,
  output logic                  o_ir_regfile_selection,
  output logic                  o_ir_read_or_write_en,
  output logic [ADDR_WIDTH-1:0] o_ir_pointer,
  output logic [DATA_WIDTH-1:0] o_ir_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] count;

`ifdef IR_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] expected_sum;

  // Sum of the words accepted so far plus the one completing the transfer
  // is already in o_checksum by the time the final WRITE retires.
  function automatic logic sum_mismatch(input logic [DATA_WIDTH-1:0] sum,
                                        input logic [DATA_WIDTH-1:0] exp_sum);
    return sum != exp_sum;
  endfunction
`endif

  // Load sequencer: state, transfer bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      ptr                    <= '0;
      count                  <= '0;
      o_data_ready           <= 1'b0;
      o_ir_regfile_en        <= 1'b0;
      o_ir_regfile_selection <= 1'b0;
      o_ir_read_or_write_en  <= 1'b0;
      o_ir_pointer           <= '0;
      o_ir_data              <= '0;
      o_busy                 <= 1'b0;
      o_done                 <= 1'b0;
      o_error                <= 1'b0;
`ifdef IR_LOADER_CHECKSUM_EN
      expected_sum           <= '0;
      o_checksum             <= '0;
`endif
    end else begin
      // Single-cycle strobes default low every cycle.
      o_done                <= 1'b0;
      o_error               <= 1'b0;
      o_ir_regfile_en       <= 1'b0;
      o_ir_read_or_write_en <= 1'b0;

      case (state)
        S_IDLE: begin
          // A start in the same cycle as an abort is honoured; abort is a no-op here.
          if (i_load_start) begin
            ptr                    <= i_load_base;
            count                  <= i_load_len;
            o_ir_regfile_selection <= i_bank;
`ifdef IR_LOADER_CHECKSUM_EN
            expected_sum           <= i_expected_sum;
            o_checksum             <= '0;
`endif
            if (i_load_len != '0) begin
              state        <= S_LOAD;
              o_data_ready <= 1'b1;
              o_busy       <= 1'b1;
            end else begin
              state  <= S_DONE;
              o_done <= 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
              // Empty transfer sums to zero.
              o_error <= sum_mismatch('0, i_expected_sum);
`endif
            end
          end
        end

        S_LOAD: begin
          if (i_load_abort) begin
            // Drop any word offered this cycle; nothing reaches the regfile.
            state        <= S_IDLE;
            o_data_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_error      <= 1'b1;
          end else if (i_data_valid && o_data_ready) begin
            state                 <= S_WRITE;
            o_data_ready          <= 1'b0;
            o_ir_pointer          <= ptr;
            o_ir_data             <= i_data;
            o_ir_regfile_en       <= 1'b1;
            o_ir_read_or_write_en <= 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
            o_checksum            <= o_checksum + i_data;
`endif
          end
        end

        S_WRITE: begin
          if (i_load_abort) begin
            state        <= S_IDLE;
            o_data_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_error      <= 1'b1;
          end else begin
            // Pointer wraps silently at the top of the address space.
            ptr   <= ptr + ADDR_WIDTH'(1);
            count <= count - ADDR_WIDTH'(1);
            if (count == ADDR_WIDTH'(1)) begin
              state  <= S_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
`ifdef IR_LOADER_CHECKSUM_EN
              o_error <= sum_mismatch(o_checksum, expected_sum);
`endif
            end else begin
              state        <= S_LOAD;
              o_data_ready <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state        <= S_IDLE;
          o_data_ready <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_loader.sv
// Directed testbench for ir_loader. Define IR_LOADER_CHECKSUM_EN for both
// files to also exercise the checksum option.
module tb_ir_loader;

  logic        clk;
  logic        rst_n;
  logic        i_load_start;
  logic [7:0]  i_load_base;
  logic [7:0]  i_load_len;
  logic        i_bank;
  logic        i_load_abort;
  logic        i_data_valid;
  logic [15:0] i_data;
  logic        o_data_ready;
  logic        o_ir_regfile_en;
  logic        o_ir_regfile_selection;
  logic        o_ir_read_or_write_en;
  logic [7:0]  o_ir_pointer;
  logic [15:0] o_ir_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
`ifdef IR_LOADER_CHECKSUM_EN
  logic [15:0] i_expected_sum;
  logic [15:0] o_checksum;
`endif

  ir_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .i_load_start           (i_load_start),
    .i_load_base            (i_load_base),
    .i_load_len             (i_load_len),
    .i_bank                 (i_bank),
    .i_load_abort           (i_load_abort),
    .i_data_valid           (i_data_valid),
    .i_data                 (i_data),
`ifdef IR_LOADER_CHECKSUM_EN
    .i_expected_sum         (i_expected_sum),
    .o_checksum             (o_checksum),
`endif
    .o_data_ready           (o_data_ready),
    .o_ir_regfile_en        (o_ir_regfile_en),
    .o_ir_regfile_selection (o_ir_regfile_selection),
    .o_ir_read_or_write_en  (o_ir_read_or_write_en),
    .o_ir_pointer           (o_ir_pointer),
    .o_ir_data              (o_ir_data),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_error                (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0]  wr_ptr[$];
  logic [15:0] wr_data[$];
  logic        wr_sel[$];
  int done_n, err_n, errdone_n, busy_n, bad_rw;
  int first_acc, done_cyc;
  logic [15:0] words[4];

  // Regfile write-port and status pulse recorder.
  always @(posedge clk) begin
    if (o_ir_regfile_en) begin
      wr_ptr.push_back(o_ir_pointer);
      wr_data.push_back(o_ir_data);
      wr_sel.push_back(o_ir_regfile_selection);
    end
    if (o_done) done_n++;
    if (o_error) err_n++;
    if (o_error && o_done) errdone_n++;
    if (o_busy) busy_n++;
    if (o_ir_read_or_write_en !== o_ir_regfile_en) bad_rw++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_ptr.delete();
    wr_data.delete();
    wr_sel.delete();
    done_n = 0; err_n = 0; errdone_n = 0; busy_n = 0; bad_rw = 0;
  endtask

  // Start a load, then feed words with an optional stall after each accept,
  // an optional one-cycle abort and an optional stray start (cycle indices
  // count from the first cycle in LOAD; -1 disables).
  task automatic run_load(input logic [7:0] base, input logic [7:0] len, input logic bank,
                          input int stall, input int abort_cyc, input int start_cyc,
                          input int ncyc);
    int k;
    int gap;
    logic acc;
    k = 0; gap = 0; first_acc = -1; done_cyc = -1;
    i_load_base = base; i_load_len = len; i_bank = bank;
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      i_data       = (k < 4) ? words[k] : 16'hDEAD;
      i_data_valid = (gap == 0);
      i_load_abort = (c == abort_cyc);
      i_load_start = (c == start_cyc);
      if (c == start_cyc) begin
        i_load_base = 8'h40; i_load_len = 8'd9; i_bank = ~bank;
      end
      acc = o_data_ready && i_data_valid;
      tick();
      if (o_done && done_cyc < 0) done_cyc = c + 1;
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        k++;
        gap = stall;
      end else if (gap > 0) begin
        gap--;
      end
    end
    i_load_start = 1'b0; i_load_abort = 1'b0; i_data_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_load_start = 1'b0; i_load_base = '0; i_load_len = '0;
    i_bank = 1'b0; i_load_abort = 1'b0; i_data_valid = 1'b0; i_data = '0;
`ifdef IR_LOADER_CHECKSUM_EN
    i_expected_sum = '0;
`endif
    clear_logs();
    tick(); tick();

    // Reset state
    chk("rst_ready", 32'(o_data_ready), 32'd0);
    chk("rst_en",    32'(o_ir_regfile_en), 32'd0);
    chk("rst_rw",    32'(o_ir_read_or_write_en), 32'd0);
    chk("rst_sel",   32'(o_ir_regfile_selection), 32'd0);
    chk("rst_busy",  32'(o_busy), 32'd0);
    chk("rst_done",  32'(o_done), 32'd0);
    chk("rst_err",   32'(o_error), 32'd0);
    chk("rst_ptr",   32'(o_ir_pointer), 32'd0);
    chk("rst_data",  32'(o_ir_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic three-word load into bank 1 with valid held high
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003; words[3] = 16'hA004;
    clear_logs();
    run_load(8'h10, 8'd3, 1'b1, 0, -1, -1, 10);
    chk("t1_nwr",  32'(wr_ptr.size()), 32'd3);
    chk("t1_p0",   32'(wr_ptr[0]), 32'h10);
    chk("t1_p1",   32'(wr_ptr[1]), 32'h11);
    chk("t1_p2",   32'(wr_ptr[2]), 32'h12);
    chk("t1_d0",   32'(wr_data[0]), 32'hA001);
    chk("t1_d2",   32'(wr_data[2]), 32'hA003);
    chk("t1_sel",  32'({wr_sel[0], wr_sel[1], wr_sel[2]}), 32'b111);
    chk("t1_done", 32'(done_n), 32'd1);
    chk("t1_lat",  32'(done_cyc - first_acc), 32'd6);
    chk("t1_err",  32'(err_n), 32'd0);
    chk("t1_busy_end", 32'(o_busy), 32'd0);

    // Pointer wraps past the top of the address space
    clear_logs();
    run_load(8'hFE, 8'd3, 1'b0, 0, -1, -1, 10);
    chk("t2_nwr", 32'(wr_ptr.size()), 32'd3);
    chk("t2_p0",  32'(wr_ptr[0]), 32'hFE);
    chk("t2_p1",  32'(wr_ptr[1]), 32'hFF);
    chk("t2_p2",  32'(wr_ptr[2]), 32'h00);
    chk("t2_sel", 32'(wr_sel[0]), 32'd0);

    // Zero-length load completes at once without writing
    clear_logs();
    i_load_base = 8'h22; i_load_len = 8'd0; i_bank = 1'b1; i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
    chk("t3_done_now", 32'(o_done), 32'd1);
    chk("t3_busy_now", 32'(o_busy), 32'd0);
    tick();
    chk("t3_done_off", 32'(o_done), 32'd0);
    tick();
    chk("t3_nwr",  32'(wr_ptr.size()), 32'd0);
    chk("t3_done", 32'(done_n), 32'd1);
    chk("t3_busy", 32'(busy_n), 32'd0);

    // Abort in the WRITE cycle of the second word: both writes already issued
    clear_logs();
    run_load(8'h30, 8'd4, 1'b0, 0, 3, -1, 10);
    chk("t4a_nwr",  32'(wr_ptr.size()), 32'd2);
    chk("t4a_p1",   32'(wr_ptr[1]), 32'h31);
    chk("t4a_err",  32'(err_n), 32'd1);
    chk("t4a_done", 32'(done_n), 32'd0);
    chk("t4a_busy", 32'(o_busy), 32'd0);

    // Abort in the same cycle the second word is offered: its write is dropped
    clear_logs();
    run_load(8'h30, 8'd4, 1'b0, 0, 2, -1, 10);
    chk("t4b_nwr",  32'(wr_ptr.size()), 32'd1);
    chk("t4b_p0",   32'(wr_ptr[0]), 32'h30);
    chk("t4b_err",  32'(err_n), 32'd1);
    chk("t4b_done", 32'(done_n), 32'd0);

    // Abort together with start while idle: start wins
    clear_logs();
    i_load_abort = 1'b1;
    run_load(8'h50, 8'd1, 1'b1, 0, -1, -1, 6);
    chk("t4c_nwr",  32'(wr_ptr.size()), 32'd1);
    chk("t4c_p0",   32'(wr_ptr[0]), 32'h50);
    chk("t4c_err",  32'(err_n), 32'd0);
    chk("t4c_done", 32'(done_n), 32'd1);

    // Five-cycle stalls between words with a stray start mid-load
    clear_logs();
    run_load(8'h20, 8'd2, 1'b0, 5, -1, 3, 16);
    chk("t5_nwr",  32'(wr_ptr.size()), 32'd2);
    chk("t5_p0",   32'(wr_ptr[0]), 32'h20);
    chk("t5_p1",   32'(wr_ptr[1]), 32'h21);
    chk("t5_d1",   32'(wr_data[1]), 32'hA002);
    chk("t5_sel",  32'({wr_sel[0], wr_sel[1]}), 32'b00);
    chk("t5_done", 32'(done_n), 32'd1);
    chk("t5_dcyc", 32'(done_cyc), 32'd8);
    chk("t5_busy", 32'(o_busy), 32'd0);

    // Reset during a WRITE discards the transfer
    clear_logs();
    run_load(8'h60, 8'd4, 1'b1, 0, -1, -1, 1);
    chk("t6_pre_en", 32'(o_ir_regfile_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_en",   32'(o_ir_regfile_en), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    chk("t6_rst_ptr",  32'(o_ir_pointer), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    i_data_valid = 1'b1;
    repeat (8) tick();
    i_data_valid = 1'b0;
    chk("t6_nwr",  32'(wr_ptr.size()), 32'd0);
    chk("t6_busy", 32'(busy_n), 32'd0);

`ifdef IR_LOADER_CHECKSUM_EN
    // 0x0001 + 0xFFFF wraps to 0x0000
    words[0] = 16'h0001; words[1] = 16'hFFFF;
    clear_logs();
    i_expected_sum = 16'h0000;
    run_load(8'h00, 8'd2, 1'b0, 0, -1, -1, 8);
    chk("cs_ok_sum",  32'(o_checksum), 32'h0000);
    chk("cs_ok_done", 32'(done_n), 32'd1);
    chk("cs_ok_err",  32'(err_n), 32'd0);
    clear_logs();
    i_expected_sum = 16'h0001;
    run_load(8'h00, 8'd2, 1'b0, 0, -1, -1, 8);
    chk("cs_bad_done", 32'(done_n), 32'd1);
    chk("cs_bad_err",  32'(errdone_n), 32'd1);
`endif

    chk("rw_follows_en", 32'(bad_rw), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ir_loader.md
IR_LOADER -- requirements
Module: ir_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, IR regfile pointer width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_load_start  input  1  one-cycle load request; honoured only in IDLE.
REQ-006 SHALL have port i_load_base  input  ADDR_WIDTH  first IR regfile address, sampled with i_load_start.
REQ-007 SHALL have port i_load_len  input  ADDR_WIDTH  word count, sampled with i_load_start.
REQ-008 SHALL have port i_bank  input  1  IR regfile bank, sampled with i_load_start.
REQ-009 SHALL have port i_load_abort  input  1  abort request.
REQ-010 SHALL have port i_data_valid  input  1  upstream word valid.
REQ-011 SHALL have port i_data  input  DATA_WIDTH  upstream instruction word.
REQ-012 SHALL have port o_data_ready  output  1  loader accepts word this cycle.
REQ-013 SHALL have ports o_ir_regfile_en (1), o_ir_regfile_selection (1), o_ir_read_or_write_en (1, 1=write), o_ir_pointer (ADDR_WIDTH), o_ir_data (DATA_WIDTH), all outputs, forming the IR regfile write port.
REQ-014 SHALL have ports o_busy, o_done, o_error  output  1 each  status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-016 IDLE: on i_load_start, latch base/len/bank; go LOAD if len!=0, else DONE.
REQ-017 LOAD: o_data_ready=1; word accepted when i_data_valid&&o_data_ready; accepted word and current pointer register, go WRITE.
REQ-018 WRITE: exactly one cycle with o_ir_regfile_en=1, o_ir_read_or_write_en=1, o_ir_selection=latched bank, o_ir_pointer/o_ir_data = registered values; o_data_ready=0.
REQ-019 After WRITE: pointer increments by 1 modulo 2^ADDR_WIDTH (wrap 0xFF->0x00 silently), remaining count decrements; go DONE when count reaches 0, else LOAD.
REQ-020 Latency: accepted word is written on the cycle following acceptance; max throughput one word per 2 cycles.
REQ-021 DONE: o_done=1 for exactly one cycle, then IDLE.
REQ-022 o_busy=1 in LOAD and WRITE, else 0.
REQ-023 i_load_start while not IDLE SHALL be ignored; no re-latching.
REQ-024 i_load_abort in LOAD or WRITE SHALL return to IDLE next cycle, pulse o_error one cycle, suppress the pending WRITE strobe; abort in IDLE/DONE ignored.
REQ-025 Abort and start in the same IDLE cycle: start wins.
REQ-026 o_ir_regfile_en, o_ir_read_or_write_en SHALL be 0 in all states except WRITE.

Reset
REQ-027 rst_n low SHALL immediately force IDLE; o_data_ready, o_ir_regfile_en, o_ir_read_or_write_en, o_ir_regfile_selection, o_busy, o_done, o_error = 0; o_ir_pointer, o_ir_data, count = 0.
REQ-028 Reset mid-load SHALL discard the transfer with no write strobe after deassertion.

Configuration
REQ-029 With IR_LOADER_CHECKSUM_EN defined: add input i_expected_sum (DATA_WIDTH) sampled with i_load_start and output o_checksum (DATA_WIDTH); each accepted word adds into o_checksum modulo 2^DATA_WIDTH (cleared at start); on entering DONE, mismatch with i_expected_sum SHALL pulse o_error together with o_done.
REQ-030 Without IR_LOADER_CHECKSUM_EN: those ports absent; o_error only from abort.

Verification
REQ-031 Start base=0x10 len=3 bank=1, words 0xA001,0xA002,0xA003 valid always -> writes at 0x10,0x11,0x12 bank 1, one o_done 6 cycles after first accept.
REQ-032 base=0xFE len=3 -> writes at 0xFE,0xFF,0x00.
REQ-033 len=0 start -> o_done next cycle, no write strobe, o_busy stays 0.
REQ-034 Abort after second of four words accepted -> exactly one write (or two if second WRITE already issued before abort cycle), o_error one cycle, o_done never.
REQ-035 Valid stalled 5 cycles between words, start pulsed mid-load -> no extra writes, parameters unchanged.
REQ-036 CHECKSUM_EN, words 0x0001,0xFFFF, expected 0x0000 -> o_done, o_error=0; expected 0x0001 -> o_error with o_done.
